// File: rtl/free_slot_allocator_pkg.sv
// ============================================================================
// Module  : free_slot_allocator_pkg
// Brief   : Shared constants and the clog2 helper for the slot allocator.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package free_slot_allocator_pkg;

  localparam int DEFAULT_WORD_WIDTH = 8;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/free_slot_allocator_if.sv
// ============================================================================
// Module  : free_slot_allocator_if
// Brief   : Allocate/release handshake and status bundle for the allocator.
//           release_error exists only when RELEASE_CHECK_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface free_slot_allocator_if
  import free_slot_allocator_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) ();

  localparam int INDEX_WIDTH = clog2(WORD_WIDTH);

  logic                   alloc_valid;
  logic                   alloc_ready;
  logic [WORD_WIDTH-1:0]  alloc_onehot;
  logic [INDEX_WIDTH-1:0] alloc_index;
  logic                   release_valid;
  logic [WORD_WIDTH-1:0]  release_onehot;
  logic [WORD_WIDTH-1:0]  busy_bitmap;
  logic                   full;
  logic                   empty;
`ifdef RELEASE_CHECK_EN
  logic                   release_error;
`endif

  modport master (
    output alloc_valid, release_valid, release_onehot,
    input  alloc_ready, alloc_onehot, alloc_index, busy_bitmap, full, empty
`ifdef RELEASE_CHECK_EN
    , input release_error
`endif
  );

  modport slave (
    input  alloc_valid, release_valid, release_onehot,
    output alloc_ready, alloc_onehot, alloc_index, busy_bitmap, full, empty
`ifdef RELEASE_CHECK_EN
    , output release_error
`endif
  );

endinterface

`default_nettype wire

// File: rtl/free_slot_allocator_bitmask.sv
// ============================================================================
// Module  : Bitmask_1_Bit_at_Rightmost_0_Bit
// Brief   : One-hot mask of the lowest clear bit of word_in; 0 when all set.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module Bitmask_1_Bit_at_Rightmost_0_Bit #(
  parameter int WORD_WIDTH = 8
) (
  input  logic [WORD_WIDTH-1:0] word_in,
  output logic [WORD_WIDTH-1:0] word_out
);

  localparam logic [WORD_WIDTH-1:0] ONE_LSB = WORD_WIDTH'(1);

  // The +1 carry stops at the lowest 0 bit, which is then the only bit set in
  // both (word_in + 1) and ~word_in. All-ones wraps to 0, giving no candidate.
  assign word_out = ~word_in & (word_in + ONE_LSB);

endmodule

`default_nettype wire

// File: rtl/free_slot_allocator.sv
// ============================================================================
// Module  : free_slot_allocator
// Brief   : Busy-bitmap slot pool granting the rightmost free slot; optional
//           release checking under the RELEASE_CHECK_EN macro.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module free_slot_allocator
  import free_slot_allocator_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
  input  logic                 clock,
  input  logic                 clear,
  free_slot_allocator_if.slave bus
);

  localparam int INDEX_WIDTH = clog2(WORD_WIDTH);
  localparam logic [WORD_WIDTH-1:0] ONE_LSB = WORD_WIDTH'(1);

  logic [WORD_WIDTH-1:0]  busy;
  logic [WORD_WIDTH-1:0]  candidate;
  logic [WORD_WIDTH-1:0]  rel;
  logic [INDEX_WIDTH-1:0] index;
  logic                   fire;

  Bitmask_1_Bit_at_Rightmost_0_Bit #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_bitmask (
    .word_in  (busy),
    .word_out (candidate)
  );

  // candidate is one-hot or zero, so OR-ing the set positions is an encoder.
  always_comb begin
    index = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (candidate[i]) begin
        index = index | INDEX_WIDTH'(i);
      end
    end
  end

  assign fire = bus.alloc_valid & bus.alloc_ready;

`ifdef RELEASE_CHECK_EN
  logic release_onehot_ok;
  logic release_bad;
  logic release_error_q;

  always_comb begin
    release_onehot_ok = (bus.release_onehot != '0) &&
                        ((bus.release_onehot & (bus.release_onehot - ONE_LSB)) == '0);
    release_bad       = bus.release_valid &&
                        (!release_onehot_ok || ((bus.release_onehot & busy) == '0));
  end

  assign rel = (bus.release_valid && !release_bad) ? bus.release_onehot : '0;

  always_ff @(posedge clock) begin
    if (clear) begin
      release_error_q <= 1'b0;
    end else begin
      release_error_q <= release_bad;
    end
  end

  assign bus.release_error = release_error_q;
`else
  // Unchecked: any addressed bit is freed, multi-hot included.
  assign rel = bus.release_valid ? bus.release_onehot : '0;
`endif

  always_ff @(posedge clock) begin
    if (clear) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~rel) | (fire ? candidate : '0);
    end
  end

  assign bus.alloc_ready  = |candidate;
  assign bus.alloc_onehot = candidate;
  assign bus.alloc_index  = index;
  assign bus.busy_bitmap  = busy;
  assign bus.full         = &busy;
  assign bus.empty        = ~|busy;

endmodule

`default_nettype wire
